hovalaag_run_ctrl: RTL and testbench

Run controller that sequences one Hovalaag CPU through a complete program run. It owns the 256×32 program store and the IN1/IN2 input buffers, and holds the CPU in reset while the host loads them. It releases the CPU for a run and streams captured OUT1/OUT2 results back to the host. The run ends on an output-count target, a host abort, or a cycle watchdog.

---
 rtl/hovalaag_run_pkg.sv | 26 ++
 rtl/hovalaag_in_buf.sv | 68 ++++++
 rtl/hovalaag_run_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_hovalaag_run_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hovalaag_run_pkg.sv
// Shared types and constants for the Hovalaag run controller.
//   run_state_e : controller state (idle / running / draining the last output)
//   ld_sel_e    : host load target codes
//   PROG_DEPTH  : program store depth, addressed by the 8-bit CPU program counter
//   DATA_W      : width of CPU input/output words
package hovalaag_run_pkg;

    localparam int unsigned PROG_DEPTH = 256;
    localparam int unsigned PROG_AW    = 8;
    localparam int unsigned INSTR_W    = 32;
    localparam int unsigned DATA_W     = 12;

    typedef enum logic [1:0] {
        LD_PROG  = 2'd0,
        LD_IN1   = 2'd1,
        LD_IN2   = 2'd2,
        LD_CLEAR = 2'd3
    } ld_sel_e;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain
    } run_state_e;

endpackage

// File: rtl/hovalaag_in_buf.sv
// Input word buffer feeding one CPU input port.
//   clk, rst   : clock, synchronous active-high reset (empties the buffer)
//   wr_en      : append wr_data at the write pointer (ignored when full)
//   wr_data    : word to append
//   wp_clr     : empty the buffer (write and read pointers to 0)
//   rd_adv     : consume the head word (ignored when empty)
//   rp_rewind  : rewind the read pointer to the first word, contents kept
//   head       : current head word, 0 when empty
//   empty/full : occupancy flags
module hovalaag_in_buf
    import hovalaag_run_pkg::*;
#(
    parameter int unsigned Depth = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wp_clr,
    input  logic              rd_adv,
    input  logic              rp_rewind,
    output logic [DATA_W-1:0] head,
    output logic              empty,
    output logic              full
);

    localparam int unsigned AW = $clog2(Depth);

    logic [DATA_W-1:0] mem [Depth];
    // One extra pointer bit: the write pointer only ever counts up from 0, so
    // its MSB alone marks a full buffer.
    logic [AW:0] wp_q;
    logic [AW:0] rp_q;
    logic        do_write;
    logic        do_read;

    assign empty    = (rp_q == wp_q);
    assign full     = wp_q[AW];
    assign do_write = wr_en && !full;
    assign do_read  = rd_adv && !empty;
    assign head     = empty ? '0 : mem[rp_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q <= '0;
            rp_q <= '0;
        end else begin
            if (wp_clr) begin
                wp_q <= '0;
            end else if (do_write) begin
                wp_q <= wp_q + {{AW{1'b0}}, 1'b1};
            end
            // Clearing also rewinds the reader so rp never sits beyond wp.
            if (wp_clr || rp_rewind) begin
                rp_q <= '0;
            end else if (do_read) begin
                rp_q <= rp_q + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wp_q[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/hovalaag_run_ctrl.sv
// Run controller sequencing one Hovalaag CPU through a program run.
// Owns the program store and both input buffers, holds the CPU in reset while
// the host loads them, then releases it and streams captured outputs back.
// Optional watchdog: define HOVALAAG_RUN_WATCHDOG_EN to end a run after
// CYCLE_LIMIT RUN cycles; otherwise timeout is tied low.
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   ld_valid/ld_sel/ld_data/ld_ready : host load channel (IDLE only)
//   start, abort, out_target       : run control; target 0 = unlimited
//   cpu_rst, cpu_instr, cpu_pc     : CPU reset and asynchronous program fetch
//   cpu_in1/2, cpu_in1/2_adv       : input buffer heads and consume strobes
//   cpu_out, cpu_out_valid, cpu_out_select : CPU output port
//   res_valid, res_sel, res_data   : captured result stream (no backpressure)
//   busy, done, underrun, timeout, cycles : status
module hovalaag_run_ctrl
    import hovalaag_run_pkg::*;
#(
    parameter int unsigned IN_DEPTH    = 64,
    parameter int unsigned CYCLE_LIMIT = 65535
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ld_valid,
    input  logic [1:0]          ld_sel,
    input  logic [INSTR_W-1:0]  ld_data,
    output logic                ld_ready,
    input  logic                start,
    input  logic                abort,
    input  logic [DATA_W-1:0]   out_target,
    output logic                cpu_rst,
    output logic [INSTR_W-1:0]  cpu_instr,
    input  logic [PROG_AW-1:0]  cpu_pc,
    output logic [DATA_W-1:0]   cpu_in1,
    output logic [DATA_W-1:0]   cpu_in2,
    input  logic                cpu_in1_adv,
    input  logic                cpu_in2_adv,
    input  logic [DATA_W-1:0]   cpu_out,
    input  logic                cpu_out_valid,
    input  logic                cpu_out_select,
    output logic                res_valid,
    output logic                res_sel,
    output logic [DATA_W-1:0]   res_data,
    output logic                busy,
    output logic                done,
    output logic                underrun,
    output logic                timeout,
    output logic [15:0]         cycles
);

    run_state_e state_q, state_d;

    logic [INSTR_W-1:0] prog [PROG_DEPTH];
    logic [PROG_AW-1:0] prog_wp_q;
    logic [DATA_W-1:0]  target_q;
    logic [DATA_W-1:0]  count_q;
    logic [15:0]        cycles_q;
    logic               done_q;
    logic               underrun_q;
    logic               res_valid_q;
    logic               res_sel_q;
    logic [DATA_W-1:0]  res_data_q;

    logic in1_empty, in1_full, in2_empty, in2_full;
    logic in_run, load_fire, start_fire, capture, hit_target, wd_fire;

    assign in_run     = (state_q == StRun);
    assign load_fire  = ld_valid && ld_ready;
    assign start_fire = (state_q == StIdle) && start;

    assign ld_ready = (state_q == StIdle) &&
                      !(((ld_sel == LD_IN1) && in1_full) || ((ld_sel == LD_IN2) && in2_full));

    // Capture stays open in DRAIN to catch an output issued in the last RUN cycle.
    assign capture    = (state_q != StIdle) && cpu_out_valid &&
                        ((target_q == '0) || (count_q < target_q));
    assign hit_target = capture && (target_q != '0) && ((count_q + 12'd1) == target_q);

`ifdef HOVALAAG_RUN_WATCHDOG_EN
    logic timeout_q;

    assign wd_fire = in_run && (cycles_q == 16'(CYCLE_LIMIT - 1));
    assign timeout = timeout_q;

    always_ff @(posedge clk) begin
        if (rst || start_fire) begin
            timeout_q <= 1'b0;
        end else if (wd_fire) begin
            timeout_q <= 1'b1;
        end
    end
`else
    logic unused_cycle_limit;

    assign unused_cycle_limit = ^CYCLE_LIMIT;
    assign wd_fire            = 1'b0;
    assign timeout            = 1'b0;
`endif

    // Program store: asynchronous read so the CPU sees its instruction in the
    // same cycle it presents the pc.
    always_ff @(posedge clk) begin
        if (load_fire && (ld_sel == LD_PROG)) begin
            prog[prog_wp_q] <= ld_data;
        end
    end

    assign cpu_instr = in_run ? prog[cpu_pc] : '0;
    assign cpu_rst   = !in_run;

    hovalaag_in_buf #(
        .Depth     (IN_DEPTH)
    ) u_in1 (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (load_fire && (ld_sel == LD_IN1)),
        .wr_data   (ld_data[DATA_W-1:0]),
        .wp_clr    (load_fire && (ld_sel == LD_CLEAR)),
        .rd_adv    (in_run && cpu_in1_adv),
        .rp_rewind (start_fire),
        .head      (cpu_in1),
        .empty     (in1_empty),
        .full      (in1_full)
    );

    hovalaag_in_buf #(
        .Depth     (IN_DEPTH)
    ) u_in2 (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (load_fire && (ld_sel == LD_IN2)),
        .wr_data   (ld_data[DATA_W-1:0]),
        .wp_clr    (load_fire && (ld_sel == LD_CLEAR)),
        .rd_adv    (in_run && cpu_in2_adv),
        .rp_rewind (start_fire),
        .head      (cpu_in2),
        .empty     (in2_empty),
        .full      (in2_full)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StRun;
            StRun:   if (abort || hit_target || wd_fire) state_d = StDrain;
            StDrain: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            prog_wp_q   <= '0;
            target_q    <= '0;
            count_q     <= '0;
            cycles_q    <= '0;
            done_q      <= 1'b0;
            underrun_q  <= 1'b0;
            res_valid_q <= 1'b0;
            res_sel_q   <= 1'b0;
            res_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            res_valid_q <= capture;

            if (load_fire && (ld_sel == LD_CLEAR)) begin
                prog_wp_q <= '0;
            end else if (load_fire && (ld_sel == LD_PROG)) begin
                prog_wp_q <= prog_wp_q + 8'd1;
            end

            if (start_fire) begin
                target_q   <= out_target;
                count_q    <= '0;
                cycles_q   <= '0;
                done_q     <= 1'b0;
                underrun_q <= 1'b0;
            end else begin
                if (capture) begin
                    count_q <= count_q + 12'd1;
                end
                // The watchdog cycle itself is not counted, leaving cycles at
                // CYCLE_LIMIT-1 after CYCLE_LIMIT RUN cycles.
                if (in_run && !wd_fire && (cycles_q != 16'hFFFF)) begin
                    cycles_q <= cycles_q + 16'd1;
                end
                if (state_q == StDrain) begin
                    done_q <= 1'b1;
                end
                if (in_run && ((cpu_in1_adv && in1_empty) || (cpu_in2_adv && in2_empty))) begin
                    underrun_q <= 1'b1;
                end
            end

            if (capture) begin
                res_data_q <= cpu_out;
                res_sel_q  <= cpu_out_select;
            end
        end
    end

    assign busy      = (state_q != StIdle);
    assign done      = done_q;
    assign underrun  = underrun_q;
    assign cycles    = cycles_q;
    assign res_valid = res_valid_q;
    assign res_sel   = res_sel_q;
    assign res_data  = res_data_q;

endmodule

// File: tb/tb_hovalaag_run_ctrl.sv
// Directed bench for hovalaag_run_ctrl. A tiny behavioural CPU executes a toy
// encoding fetched from cpu_instr:
//   bit0 consume IN1, bit4 consume IN2, bit1 emit cpu_in1 on OUT next cycle,
//   bit3 output select, bit2 jump to [15:8] (else pc+1).
module tb_hovalaag_run_ctrl;

    localparam int unsigned IN_DEPTH = 64;
`ifdef HOVALAAG_RUN_WATCHDOG_EN
    localparam int unsigned CYCLE_LIMIT = 20;
`else
    localparam int unsigned CYCLE_LIMIT = 65535;
`endif

    logic        clk;
    logic        rst;
    logic        ld_valid;
    logic [1:0]  ld_sel;
    logic [31:0] ld_data;
    logic        ld_ready;
    logic        start;
    logic        abort;
    logic [11:0] out_target;
    logic        cpu_rst;
    logic [31:0] cpu_instr;
    logic [7:0]  cpu_pc;
    logic [11:0] cpu_in1, cpu_in2;
    logic        cpu_in1_adv, cpu_in2_adv;
    logic [11:0] cpu_out;
    logic        cpu_out_valid;
    logic        cpu_out_select;
    logic        res_valid;
    logic        res_sel;
    logic [11:0] res_data;
    logic        busy, done, underrun, timeout;
    logic [15:0] cycles;

    int tests_run = 0;
    int failed    = 0;
    int base;

    logic [11:0] rlog_data [256];
    logic        rlog_sel  [256];
    int          res_total = 0;

    hovalaag_run_ctrl #(
        .IN_DEPTH       (IN_DEPTH),
        .CYCLE_LIMIT    (CYCLE_LIMIT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ld_valid       (ld_valid),
        .ld_sel         (ld_sel),
        .ld_data        (ld_data),
        .ld_ready       (ld_ready),
        .start          (start),
        .abort          (abort),
        .out_target     (out_target),
        .cpu_rst        (cpu_rst),
        .cpu_instr      (cpu_instr),
        .cpu_pc         (cpu_pc),
        .cpu_in1        (cpu_in1),
        .cpu_in2        (cpu_in2),
        .cpu_in1_adv    (cpu_in1_adv),
        .cpu_in2_adv    (cpu_in2_adv),
        .cpu_out        (cpu_out),
        .cpu_out_valid  (cpu_out_valid),
        .cpu_out_select (cpu_out_select),
        .res_valid      (res_valid),
        .res_sel        (res_sel),
        .res_data       (res_data),
        .busy           (busy),
        .done           (done),
        .underrun       (underrun),
        .timeout        (timeout),
        .cycles         (cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural CPU
    logic [7:0]  m_pc;
    logic [11:0] m_out;
    logic        m_ov, m_sel;

    assign cpu_pc         = m_pc;
    assign cpu_out        = m_out;
    assign cpu_out_valid  = m_ov;
    assign cpu_out_select = m_sel;
    assign cpu_in1_adv    = !cpu_rst && cpu_instr[0];
    assign cpu_in2_adv    = !cpu_rst && cpu_instr[4];

    always @(posedge clk) begin
        if (cpu_rst) begin
            m_pc  <= 8'd0;
            m_out <= 12'd0;
            m_ov  <= 1'b0;
            m_sel <= 1'b0;
        end else begin
            m_pc  <= cpu_instr[2] ? cpu_instr[15:8] : m_pc + 8'd1;
            m_out <= cpu_in1;
            m_ov  <= cpu_instr[1];
            m_sel <= cpu_instr[3];
        end
    end

    always @(negedge clk) begin
        if (res_valid === 1'b1 && res_total < 256) begin
            rlog_data[res_total] = res_data;
            rlog_sel[res_total]  = res_sel;
            res_total++;
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish, observed t=%0t required <100000",
                 $time);
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [1:0] sel, input logic [31:0] d);
        ld_sel   = sel;
        ld_data  = d;
        ld_valid = 1'b1;
        tick();
        ld_valid = 1'b0;
    endtask

    task automatic start_run(input logic [11:0] tgt);
        out_target = tgt;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy !== 1'b0 && n < 200) begin
            tick();
            n++;
        end
        check(tag, {31'd0, busy}, 32'd0);
        tick();
    endtask

    initial begin
        rst = 1'b1; ld_valid = 1'b0; ld_sel = 2'd0; ld_data = '0;
        start = 1'b0; abort = 1'b0; out_target = '0;
        tick(); tick();

        // Reset state
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_underrun", underrun, 0);
        check("rst_timeout", timeout, 0);
        check("rst_cycles", cycles, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_sel", res_sel, 0);
        check("rst_res_data", res_data, 0);
        check("rst_ld_ready", ld_ready, 1);
        check("rst_cpu_rst", cpu_rst, 1);
        check("rst_cpu_instr", cpu_instr, 0);
        rst = 1'b0;

        // Run 1: read IN1 and emit it; jump 0. IN1 = 5,7,9, target 3.
        load(2'd0, 32'h3);
        load(2'd0, 32'h4);
        load(2'd1, 32'd5);
        load(2'd1, 32'd7);
        load(2'd1, 32'd9);
        check("t1_head_idle", cpu_in1, 5);
        check("t1_instr_idle", cpu_instr, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t1_abort_idle_ignored", busy, 0);
        base = res_total;
        start_run(12'd3);
        check("t1_cpu_rst_run", cpu_rst, 0);
        check("t1_busy_run", busy, 1);
        check("t1_first_instr", cpu_instr, 32'h3);
        check("t1_cycles_first", cycles, 0);
        check("t1_ld_ready_run", ld_ready, 0);
        wait_idle("t1_idle");
        check("t1_count", res_total - base, 3);
        check("t1_res0", rlog_data[base], 5);
        check("t1_res1", rlog_data[base+1], 7);
        check("t1_res2", rlog_data[base+2], 9);
        check("t1_sel", {rlog_sel[base], rlog_sel[base+1], rlog_sel[base+2]}, 0);
        check("t1_done", done, 1);
        check("t1_underrun", underrun, 0);
        check("t1_cycles", cycles, 6);

        // Run 2: IN1 = 4,6 only, target 3 -> underrun, third result 0.
        load(2'd3, 32'd0);
        load(2'd0, 32'h3);
        load(2'd0, 32'h4);
        load(2'd1, 32'd4);
        load(2'd1, 32'd6);
        base = res_total;
        start_run(12'd3);
        check("t2_done_cleared", done, 0);
        wait_idle("t2_idle");
        check("t2_count", res_total - base, 3);
        check("t2_res0", rlog_data[base], 4);
        check("t2_res1", rlog_data[base+1], 6);
        check("t2_res2", rlog_data[base+2], 0);
        check("t2_underrun", underrun, 1);
        check("t2_done", done, 1);
        check("t2_cycles", cycles, 6);

        // Run 3: repeat without reloading.
        base = res_total;
        start_run(12'd3);
        check("t3_cycles_restart", cycles, 0);
        check("t3_underrun_cleared", underrun, 0);
        wait_idle("t3_idle");
        check("t3_count", res_total - base, 3);
        check("t3_res0", rlog_data[base], 4);
        check("t3_res1", rlog_data[base+1], 6);
        check("t3_res2", rlog_data[base+2], 0);
        check("t3_underrun", underrun, 1);
        check("t3_cycles", cycles, 6);

        // Run 4: emit IN1 head every cycle with sel=1, unlimited, abort in RUN cycle 10.
        load(2'd3, 32'd0);
        load(2'd0, 32'hE);
        load(2'd1, 32'd33);
        base = res_total;
        start_run(12'd0);
        repeat (9) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t4_drain_busy", busy, 1);
        check("t4_drain_cpu_rst", cpu_rst, 1);
        tick();
        check("t4_done", done, 1);
        check("t4_idle", busy, 0);
        check("t4_cycles", cycles, 10);
        tick();
        check("t4_count", res_total - base, 10);
        check("t4_last_data", rlog_data[base+9], 33);
        check("t4_last_sel", rlog_sel[base+9], 1);

`ifdef HOVALAAG_RUN_WATCHDOG_EN
        // Run 5: jump-0 loop with no output, watchdog at 20 cycles.
        load(2'd3, 32'd0);
        load(2'd0, 32'h4);
        start_run(12'd0);
        repeat (19) tick();
        check("t5_run20_cpu_rst", cpu_rst, 0);
        check("t5_run20_timeout", timeout, 0);
        check("t5_run20_cycles", cycles, 19);
        tick();
        check("t5_timeout", timeout, 1);
        check("t5_drain_cpu_rst", cpu_rst, 1);
        check("t5_cycles", cycles, 19);
        tick();
        check("t5_done", done, 1);
`else
        check("t5_timeout_tied", timeout, 0);
`endif

        // Run 6: fill IN2, ready per target, then reset mid-run.
        load(2'd3, 32'd0);
        for (int i = 0; i < IN_DEPTH; i++) begin
            load(2'd2, 32'd100 + 32'(i));
        end
        ld_sel = 2'd2; #1;
        check("t6_ready_in2_full", ld_ready, 0);
        ld_sel = 2'd0; #1;
        check("t6_ready_prog", ld_ready, 1);
        ld_sel = 2'd1; #1;
        check("t6_ready_in1", ld_ready, 1);
        check("t6_in2_head", cpu_in2, 100);
        load(2'd0, 32'h7);
        start_run(12'd0);
        tick();
        check("t6_underrun_run", underrun, 1);
        check("t6_busy_run", busy, 1);
        tick();
        check("t6_res_valid_run", res_valid, 1);
        rst = 1'b1;
        tick();
        check("t6_cpu_rst", cpu_rst, 1);
        check("t6_busy", busy, 0);
        check("t6_underrun", underrun, 0);
        check("t6_done", done, 0);
        check("t6_cycles", cycles, 0);
        check("t6_res_valid", res_valid, 0);
        check("t6_in2_empty_head", cpu_in2, 0);
        ld_sel = 2'd2; #1;
        check("t6_ready_in2_cleared", ld_ready, 1);
        rst = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
